// File: rtl/sim_fin_pkg.sv
// ============================================================================
// Module   : sim_fin_pkg
// Purpose  : Shared state/cause encodings and widths for the sim_fin responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sim_fin_pkg;

    localparam int ERR_W = 8;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_ALL_DONE = 2'd1,
        CAUSE_IDLE     = 2'd2,
        CAUSE_ERROR    = 2'd3
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RUN         = 3'd1,
        ST_DRAIN       = 3'd2,
        ST_REQ         = 3'd3,
        ST_WAIT_ACK_LO = 3'd4,
        ST_DONE        = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sim_fin_sat_cnt.sv
// ============================================================================
// Module   : sim_fin_sat_cnt
// Purpose  : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sim_fin_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/sim_fin.sv
// ============================================================================
// Module   : sim_fin
// Purpose  : Watches agent done/activity/error, drains, then raises a
//            four-phase finish handshake carrying verdict and statistics.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sim_fin
    import sim_fin_pkg::*;
#(
    parameter int AGENTS       = 4,
    parameter int DRAIN_CYCLES = 16,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int CNT_W        = 32
) (
    input  logic              sim_fin_clk_ip,
    input  logic              sim_fin_rst_n_ip,
    input  logic              sim_fin_enable_ip,
    input  logic [AGENTS-1:0] sim_fin_done_ip,
    input  logic [AGENTS-1:0] sim_fin_activity_ip,
    input  logic [AGENTS-1:0] sim_fin_error_ip,
    input  logic              sim_fin_ack_ip,
    output logic              sim_fin_req_op,
    output logic              sim_fin_pass_op,
    output logic [1:0]        sim_fin_cause_op,
    output logic [ERR_W-1:0]  sim_fin_errors_op,
    output logic [CNT_W-1:0]  sim_fin_cycles_op,
    output logic [2:0]        sim_fin_state_op
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1) + 1;
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    state_e            r_state;
    cause_e            r_cause;
    logic              r_pass;
    logic              r_req;
    logic [AGENTS-1:0] r_done;

    logic [CNT_W-1:0]  w_cyc_cnt;
    logic [ERR_W-1:0]  w_err_cnt;
    logic [IDLE_W-1:0] w_idle_cnt;
    logic [DRN_W-1:0]  w_drn_cnt;

    logic w_in_run;
    logic w_in_drain;
    logic w_start;
    logic w_err_any;
    logic w_act_any;
    logic w_all_done;
    logic w_idle_hit;
    logic w_drain_last;

    assign w_in_run     = (r_state == ST_RUN);
    assign w_in_drain   = (r_state == ST_DRAIN);
    assign w_start      = (r_state == ST_IDLE) && sim_fin_enable_ip;
    assign w_err_any    = |sim_fin_error_ip;
    assign w_act_any    = |sim_fin_activity_ip;
    assign w_all_done   = &(r_done | sim_fin_done_ip);
    assign w_idle_hit   = (IDLE_TIMEOUT != 0) && !w_act_any && (w_idle_cnt == IDLE_LAST);
    assign w_drain_last = (w_drn_cnt == DRAIN_LAST);

    sim_fin_sat_cnt #(.W(CNT_W)) u_cyc_cnt (
        .clk   (sim_fin_clk_ip),
        .rst_n (sim_fin_rst_n_ip),
        .i_clr (w_start),
        .i_inc (w_in_run || w_in_drain),
        .o_cnt (w_cyc_cnt)
    );

    // Error count is per cycle with any error bit, not per agent.
    sim_fin_sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk   (sim_fin_clk_ip),
        .rst_n (sim_fin_rst_n_ip),
        .i_clr (w_start),
        .i_inc ((w_in_run || w_in_drain) && w_err_any),
        .o_cnt (w_err_cnt)
    );

    sim_fin_sat_cnt #(.W(IDLE_W)) u_idle_cnt (
        .clk   (sim_fin_clk_ip),
        .rst_n (sim_fin_rst_n_ip),
        .i_clr (w_start || (w_in_run && w_act_any)),
        .i_inc (w_in_run && !w_act_any),
        .o_cnt (w_idle_cnt)
    );

    sim_fin_sat_cnt #(.W(DRN_W)) u_drn_cnt (
        .clk   (sim_fin_clk_ip),
        .rst_n (sim_fin_rst_n_ip),
        .i_clr (!w_in_drain),
        .i_inc (w_in_drain),
        .o_cnt (w_drn_cnt)
    );

    always_ff @(posedge sim_fin_clk_ip or negedge sim_fin_rst_n_ip) begin
        if (!sim_fin_rst_n_ip) begin
            r_state <= ST_IDLE;
            r_cause <= CAUSE_NONE;
            r_pass  <= 1'b0;
            r_req   <= 1'b0;
            r_done  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sim_fin_enable_ip) begin
                        r_state <= ST_RUN;
                        r_cause <= CAUSE_NONE;
                        r_pass  <= 1'b0;
                        r_done  <= '0;
                    end
                end
                ST_RUN: begin
                    r_done <= r_done | sim_fin_done_ip;
                    if (w_err_any) begin
                        r_state <= ST_DRAIN;
                        r_cause <= CAUSE_ERROR;
                    end else if (w_all_done) begin
                        r_state <= ST_DRAIN;
                        r_cause <= CAUSE_ALL_DONE;
                    end else if (w_idle_hit) begin
                        r_state <= ST_DRAIN;
                        r_cause <= CAUSE_IDLE;
                    end else if (!sim_fin_enable_ip) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (w_err_any) begin
                        r_cause <= CAUSE_ERROR;
                    end
                    // An error on the final drain cycle still spoils the verdict.
                    if (w_drain_last) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_pass  <= !w_err_any && (r_cause == CAUSE_ALL_DONE) && (w_err_cnt == '0);
                    end
                end
                ST_REQ: begin
                    if (sim_fin_ack_ip) begin
                        r_state <= ST_WAIT_ACK_LO;
                        r_req   <= 1'b0;
                    end
                end
                ST_WAIT_ACK_LO: begin
                    if (!sim_fin_ack_ip) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign sim_fin_req_op    = r_req;
    assign sim_fin_pass_op   = r_pass;
    assign sim_fin_cause_op  = r_cause;
    assign sim_fin_errors_op = w_err_cnt;
    assign sim_fin_cycles_op = w_cyc_cnt;
    assign sim_fin_state_op  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sim_fin.sv
// ============================================================================
// Module   : tb_sim_fin
// Purpose  : Directed self-checking bench for the sim_fin finish responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sim_fin;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r_rst_n;
    logic       r_en;
    logic [3:0] r_done;
    logic [3:0] r_act;
    logic [3:0] r_err;
    logic       r_ack;

    logic        w_req;
    logic        w_pass;
    logic [1:0]  w_cause;
    logic [7:0]  w_errors;
    logic [31:0] w_cycles;
    logic [2:0]  w_state;

    logic       r_s_en;
    logic [3:0] r_s_done;
    logic [3:0] r_s_act;
    logic [3:0] r_s_err;
    logic       r_s_ack;

    logic        w_s_req;
    logic        w_s_pass;
    logic [1:0]  w_s_cause;
    logic [7:0]  w_s_errors;
    logic [31:0] w_s_cycles;
    logic [2:0]  w_s_state;

    int n_checks = 0;
    int n_fail   = 0;

    sim_fin #(.AGENTS(4), .DRAIN_CYCLES(16), .IDLE_TIMEOUT(100), .CNT_W(32)) u_dut (
        .sim_fin_clk_ip      (clk),
        .sim_fin_rst_n_ip    (r_rst_n),
        .sim_fin_enable_ip   (r_en),
        .sim_fin_done_ip     (r_done),
        .sim_fin_activity_ip (r_act),
        .sim_fin_error_ip    (r_err),
        .sim_fin_ack_ip      (r_ack),
        .sim_fin_req_op      (w_req),
        .sim_fin_pass_op     (w_pass),
        .sim_fin_cause_op    (w_cause),
        .sim_fin_errors_op   (w_errors),
        .sim_fin_cycles_op   (w_cycles),
        .sim_fin_state_op    (w_state)
    );

    sim_fin #(.AGENTS(4), .DRAIN_CYCLES(320), .IDLE_TIMEOUT(0), .CNT_W(32)) u_sat (
        .sim_fin_clk_ip      (clk),
        .sim_fin_rst_n_ip    (r_rst_n),
        .sim_fin_enable_ip   (r_s_en),
        .sim_fin_done_ip     (r_s_done),
        .sim_fin_activity_ip (r_s_act),
        .sim_fin_error_ip    (r_s_err),
        .sim_fin_ack_ip      (r_s_ack),
        .sim_fin_req_op      (w_s_req),
        .sim_fin_pass_op     (w_s_pass),
        .sim_fin_cause_op    (w_s_cause),
        .sim_fin_errors_op   (w_s_errors),
        .sim_fin_cycles_op   (w_s_cycles),
        .sim_fin_state_op    (w_s_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        r_rst_n = 1'b0;
        r_en = 1'b0; r_done = '0; r_act = '0; r_err = '0; r_ack = 1'b0;
        r_s_en = 1'b0; r_s_done = '0; r_s_act = '0; r_s_err = '0; r_s_ack = 1'b0;
        ticks(2);
        r_rst_n = 1'b1;
    endtask

    // After this returns the DUT has just taken the IDLE->RUN edge (cycle 0).
    task automatic start(input string tag);
        r_en = 1'b1;
        tick();
        check_eq(tag, 32'(w_state), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_req",    32'(w_req),    32'd0);
        check_eq("rst_pass",   32'(w_pass),   32'd0);
        check_eq("rst_cause",  32'(w_cause),  32'd0);
        check_eq("rst_errors", 32'(w_errors), 32'd0);
        check_eq("rst_cycles", w_cycles,      32'd0);
        check_eq("rst_state",  32'(w_state),  32'd0);

        // All done: bits rise at cycles 10/20/30/40
        start("t1_run");
        r_act = '1;
        for (int c = 0; c < 41; c++) begin
            r_done = {c >= 40, c >= 30, c >= 20, c >= 10};
            if (c == 40) check_eq("t1_still_run", 32'(w_state), 32'd1);
            tick();
        end
        check_eq("t1_drain41", 32'(w_state), 32'd2);
        check_eq("t1_cause_d", 32'(w_cause), 32'd1);
        ticks(15);
        check_eq("t1_drain56", 32'(w_state), 32'd2);
        check_eq("t1_noreq56", 32'(w_req),   32'd0);
        tick();
        check_eq("t1_req57",   32'(w_req),   32'd1);
        check_eq("t1_state57", 32'(w_state), 32'd3);
        check_eq("t1_cycles",  w_cycles,     32'd57);
        check_eq("t1_pass",    32'(w_pass),  32'd1);
        check_eq("t1_cause",   32'(w_cause), 32'd1);
        check_eq("t1_errors",  32'(w_errors), 32'd0);
        ticks(3);
        check_eq("t1_req_hold", 32'(w_req),  32'd1);
        r_ack = 1'b1;
        tick();
        check_eq("t1_wait_st", 32'(w_state), 32'd4);
        check_eq("t1_req_drop", 32'(w_req),  32'd0);
        r_ack = 1'b0;
        tick();
        check_eq("t1_done_st", 32'(w_state), 32'd5);
        r_ack = 1'b1;
        r_err = 4'b0001;
        tick();
        check_eq("t1_done_hold", 32'(w_state), 32'd5);
        check_eq("t1_done_pass", 32'(w_pass),  32'd1);
        check_eq("t1_done_cyc",  w_cycles,     32'd57);
        check_eq("t1_done_err",  32'(w_errors), 32'd0);

        // Error at cycle 5, second error in DRAIN
        do_reset();
        start("t2_run");
        r_act = '1;
        ticks(5);
        r_err = 4'b0100;
        tick();
        r_err = '0;
        check_eq("t2_drain",   32'(w_state),  32'd2);
        check_eq("t2_cause",   32'(w_cause),  32'd3);
        check_eq("t2_errors1", 32'(w_errors), 32'd1);
        ticks(4);
        r_err = 4'b0001;
        tick();
        r_err = '0;
        check_eq("t2_errors2", 32'(w_errors), 32'd2);
        ticks(10);
        check_eq("t2_drain21", 32'(w_state), 32'd2);
        tick();
        check_eq("t2_req",     32'(w_req),    32'd1);
        check_eq("t2_pass",    32'(w_pass),   32'd0);
        check_eq("t2_cycles",  w_cycles,      32'd22);
        r_err = 4'b1111;
        tick();
        r_err = '0;
        check_eq("t2_err_ign", 32'(w_errors), 32'd2);

        // Idle timeout: activity through cycle 50 only
        do_reset();
        start("t3_run");
        for (int c = 0; c <= 50; c++) begin
            r_act = '1;
            tick();
        end
        r_act = '0;
        ticks(99);
        check_eq("t3_run150",   32'(w_state), 32'd1);
        tick();
        check_eq("t3_drain151", 32'(w_state), 32'd2);
        check_eq("t3_cause",    32'(w_cause), 32'd2);
        ticks(16);
        check_eq("t3_req",      32'(w_req),   32'd1);
        check_eq("t3_pass",     32'(w_pass),  32'd0);
        check_eq("t3_cycles",   w_cycles,     32'd167);

        // Last done bit and error in the same cycle
        do_reset();
        start("t4_run");
        r_act = '1;
        r_done = 4'b0111;
        ticks(3);
        r_done = 4'b1000;
        r_err = 4'b0001;
        tick();
        r_err = '0;
        check_eq("t4_drain", 32'(w_state), 32'd2);
        check_eq("t4_cause", 32'(w_cause), 32'd3);

        // All done, then error during DRAIN upgrades cause
        do_reset();
        start("t4b_run");
        r_done = 4'hF;
        tick();
        r_done = '0;
        check_eq("t4b_cause1", 32'(w_cause), 32'd1);
        ticks(2);
        r_err = 4'b0010;
        tick();
        r_err = '0;
        check_eq("t4b_cause3", 32'(w_cause),  32'd3);
        check_eq("t4b_errors", 32'(w_errors), 32'd1);
        ticks(13);
        check_eq("t4b_req",    32'(w_req),    32'd1);
        check_eq("t4b_pass",   32'(w_pass),   32'd0);

        // Reset mid-handshake, ack low
        r_rst_n = 1'b0;
        #1;
        check_eq("t5_req",    32'(w_req),    32'd0);
        check_eq("t5_state",  32'(w_state),  32'd0);
        check_eq("t5_cause",  32'(w_cause),  32'd0);
        check_eq("t5_errors", 32'(w_errors), 32'd0);
        check_eq("t5_cycles", w_cycles,      32'd0);
        check_eq("t5_pass",   32'(w_pass),   32'd0);
        tick();
        r_rst_n = 1'b1;
        start("t5_rerun");
        check_eq("t5_cyc0", w_cycles, 32'd0);
        ticks(3);
        check_eq("t5_cyc3", w_cycles, 32'd3);

        // Enable drop in RUN forgets sticky done
        do_reset();
        start("t6_run");
        r_act = '1;
        r_done = 4'b0001;
        tick();
        r_done = '0;
        ticks(2);
        r_en = 1'b0;
        tick();
        check_eq("t6_idle", 32'(w_state), 32'd0);
        r_en = 1'b1;
        tick();
        check_eq("t6_rerun", 32'(w_state), 32'd1);
        r_done = 4'b1110;
        ticks(2);
        check_eq("t6_not_done", 32'(w_state), 32'd1);
        r_done = 4'b0001;
        tick();
        check_eq("t6_drain", 32'(w_state), 32'd2);
        check_eq("t6_cause", 32'(w_cause), 32'd1);

        // Error count saturation through a 320-cycle drain
        r_s_en = 1'b1;
        tick();
        check_eq("t7_run", 32'(w_s_state), 32'd1);
        r_s_err = 4'b1000;
        ticks(200);
        check_eq("t7_err200", 32'(w_s_errors), 32'd200);
        ticks(100);
        check_eq("t7_err_sat", 32'(w_s_errors), 32'd255);
        check_eq("t7_drain",   32'(w_s_state),  32'd2);
        r_s_err = '0;
        ticks(21);
        check_eq("t7_req",     32'(w_s_req),    32'd1);
        check_eq("t7_pass",    32'(w_s_pass),   32'd0);
        check_eq("t7_cause",   32'(w_s_cause),  32'd3);
        check_eq("t7_errors",  32'(w_s_errors), 32'd255);
        check_eq("t7_cycles",  w_s_cycles,      32'd321);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
